// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N-LED count/chase/breathe/all-on pattern generator; breathe mode is built only when LED_PATTERN_BREATHE_EN is defined
module led_pattern_gen #(
    parameter int N_LEDS   = 5,
    parameter int TICK_DIV = 1200000,
    parameter int PWM_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_in,
    input  logic              mode_load,
    output logic [N_LEDS-1:0] led,
    output logic              tick
);
    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int PW = N_LEDS > 1 ? $clog2(N_LEDS) : 1;

    typedef enum logic [1:0] {M_COUNT, M_CHASE, M_BREATHE, M_ALL} mode_t;

    mode_t             mode_q, mode_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic              tick_q, tick_d;
    logic [N_LEDS-1:0] count_q, count_d;
    logic [PW-1:0]     pos_q, pos_d, pos_nx;
    logic              dir_q, dir_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              step, adv_chase, pwm_on;
`ifdef LED_PATTERN_BREATHE_EN
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] level_q, level_d, lvl_nx;
    logic                ramp_q, ramp_d, adv_lvl;
`endif

    // Next state: prescaler, mode capture (load beats a step), active-mode pattern state, LED drive from current state
    always_comb begin
        step      = div_cnt_q == DW'(TICK_DIV - 1) && !mode_load;
        div_cnt_d = (mode_load || step) ? '0 : div_cnt_q + DW'(1);
        tick_d    = step;
`ifdef LED_PATTERN_BREATHE_EN
        mode_d    = mode_load ? mode_t'(mode_in) : mode_q;
`else
        mode_d    = mode_load ? (mode_in == 2'd2 ? M_COUNT : mode_t'(mode_in)) : mode_q;
`endif
        count_d   = mode_load ? '0 : (step && mode_q == M_COUNT) ? count_q + N_LEDS'(1) : count_q;
        pos_nx    = dir_q ? pos_q - PW'(1) : pos_q + PW'(1);
        adv_chase = step && mode_q == M_CHASE && N_LEDS > 1;
        pos_d     = mode_load ? '0 : adv_chase ? pos_nx : pos_q;
        dir_d     = mode_load ? 1'b0 : !adv_chase ? dir_q :
                    pos_nx == PW'(N_LEDS - 1) ? 1'b1 : pos_nx == '0 ? 1'b0 : dir_q;
`ifdef LED_PATTERN_BREATHE_EN
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        lvl_nx    = ramp_q ? level_q - PWM_BITS'(1) : level_q + PWM_BITS'(1);
        adv_lvl   = step && mode_q == M_BREATHE;
        level_d   = mode_load ? '0 : adv_lvl ? lvl_nx : level_q;
        ramp_d    = mode_load ? 1'b0 : !adv_lvl ? ramp_q : &lvl_nx ? 1'b1 : lvl_nx == '0 ? 1'b0 : ramp_q;
        pwm_on    = pwm_cnt_q < level_q;
`else
        pwm_on    = PWM_BITS < 1;
`endif
        led_d     = mode_q == M_ALL ? '1 :
                    mode_q == M_CHASE ? N_LEDS'(1) << pos_q :
                    mode_q == M_BREATHE ? {N_LEDS{pwm_on}} : count_q;
    end

    // Core state and registered outputs; reset clears everything asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= M_COUNT;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            count_q   <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            led_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            led_q     <= led_d;
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    // Breathing PWM counter and triangle level ramp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            level_q   <= '0;
            ramp_q    <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            level_q   <= level_d;
            ramp_q    <= ramp_d;
        end
    end
`endif

    assign led  = led_q;
    assign tick = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized and directed checks of led_pattern_gen against a step-count based reference model
module tb_led_pattern_gen;
    localparam int N    = 5;
    localparam int TD   = 4;
    localparam int PB   = 3;
    localparam int CH   = 2 * N - 2;
    localparam int LMAX = (1 << PB) - 1;
    localparam int LP   = 2 * LMAX;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         mode_load = 1'b0;
    logic [1:0]   mode_in = 2'd0;
    logic [N-1:0] led;
    logic         tick;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int edges = 0;
    int mmode = 0;
    logic [N-1:0] pat = '0;

    led_pattern_gen #(.N_LEDS(N), .TICK_DIV(TD), .PWM_BITS(PB)) dut (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .mode_load(mode_load), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Pattern implied by mode, steps taken since the last restart and clocks since reset
    function automatic logic [N-1:0] pattern(input int m, input int s, input int pw);
        int p, lv;
        logic [N-1:0] one;
        one = 1;
        p   = s % CH;
        lv  = s % LP;
        lv  = lv <= LMAX ? lv : LP - lv;
        case (m)
            0:       return N'(s % (1 << N));
            1:       return one << (p < N ? p : CH - p);
            2:       return ((pw % (1 << PB)) < lv) ? {N{1'b1}} : {N{1'b0}};
            default: return {N{1'b1}};
        endcase
    endfunction

    task automatic step_clk();
        logic [N-1:0] exp_led;
        logic         exp_tick;
        @(posedge clk);
        #1;
        exp_led = pat;
        if (mode_load) begin
            cyc      = 0;
            exp_tick = 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
            mmode = int'(mode_in);
`else
            mmode = mode_in == 2'd2 ? 0 : int'(mode_in);
`endif
        end else begin
            cyc++;
            exp_tick = cyc % TD == 0;
        end
        edges++;
        pat = pattern(mmode, cyc / TD, edges);
        check("tick", tick, exp_tick);
        check("led", led, exp_led);
    endtask

    task automatic load(input int m);
        mode_in   = 2'(m);
        mode_load = 1'b1;
        step_clk();
        mode_load = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        mode_load = 1'b0;
        #1;
        check("rst_async_led", led, 0);
        check("rst_async_tick", tick, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_led", led, 0);
        rst_n = 1'b1;
        cyc   = 0;
        edges = 0;
        mmode = 0;
        pat   = '0;
    endtask

    initial begin
        #2;
        apply_reset();
        repeat (34 * TD) step_clk();
        load(1);
        repeat (10 * TD + 2) step_clk();
        load(2);
        repeat (2 * LP * TD) step_clk();
        load(0);
        for (int i = 0; i < TD && cyc % TD != TD - 1; i++) step_clk();
        mode_in   = 2'd3;
        mode_load = 1'b1;
        step_clk();
        mode_load = 1'b0;
        repeat (3 * TD) step_clk();
        load(1);
        repeat (6 * TD + 1) step_clk();
        apply_reset();
        repeat (3 * TD) step_clk();
        mode_in   = 2'd1;
        mode_load = 1'b1;
        repeat (3) step_clk();
        mode_load = 1'b0;
        repeat (3 * TD) step_clk();
        repeat (800) begin
            mode_load = $urandom_range(0, 15) == 0;
            mode_in   = 2'($urandom_range(0, 3));
            step_clk();
        end
        mode_load = 1'b0;
        repeat (2 * TD) step_clk();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator driving N status LEDs from the board clock. It is the successor to the fixed five-LED blinky top. It adds a configurable tick prescaler, LED count and PWM depth, plus run-time selectable modes: binary count, bouncing chase, PWM breathing and all-on. It sits directly behind the top-level pins and drives the LED outputs (pin_d1..pin_dN) through the `led` bus.

## Interface
- `N_LEDS`, 5: number of LED outputs (1..16).
- `TICK_DIV`, 1200000: clk cycles per pattern step (≥2); 10 Hz at 12 MHz.
- `PWM_BITS`, 8: breathing PWM resolution (2..10).
- `clk`  in  1  12 MHz board clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_in`  in  2  requested mode: 0 count, 1 chase, 2 breathe, 3 all-on.
- `mode_load`  in  1  single-cycle strobe; captures `mode_in`.
- `led`  out  N_LEDS  LED drive, active-high, registered.
- `tick`  out  1  one-cycle pulse on every pattern step, registered.

## Operation
- Prescaler `div_cnt` counts 0..TICK_DIV-1 and wraps. When `div_cnt == TICK_DIV-1`, `tick` is high for the following cycle, and the pattern state advances on that same edge.
- Mode register `mode`: on a `mode_load` edge, `mode <= mode_in`. Pattern state is cleared:
  - `count = 0`
  - `pos = 0`
  - `dir = up`
  - `level = 0`
  - `ramp = up`
  - `div_cnt = 0`
- A reload of the current mode also restarts.
- Mode 0 count: `count` increments by 1 per step, width N_LEDS, and wraps from 2^N_LEDS-1 to 0. `led = count`.
- Mode 1 chase: `led` is one-hot at `pos`.
  - Going up: `pos` increments; on reaching N_LEDS-1, `dir` flips to down.
  - Going down: `pos` decrements; on reaching 0, `dir` flips to up.
  - Sequence for N=5: 0,1,2,3,4,3,2,1,0,1,...
  - With N_LEDS=1, `pos` stays at 0.
- Mode 2 breathe: free-running `pwm_cnt` (PWM_BITS wide) increments every clk.
  - `level` steps once per tick, 0 up to 2^PWM_BITS-1, then down to 0, then repeats. Each endpoint is held for exactly one step.
  - All LED bits are `(pwm_cnt < level)`. `level = 0` means fully off.
- Mode 3: `led` is all ones. State counters are not advanced.
- Inactive-mode state registers hold their values; only the active mode's state advances.

## Timing
- Reset (asynchronous assert, synchronous release) clears:
  - `led` = 0
  - `tick` = 0
  - `mode` = 0
  - `count` = 0, `pos` = 0
  - `dir` = up, `level` = 0, `ramp` = up
  - `div_cnt` = 0, `pwm_cnt` = 0
- First `tick` comes TICK_DIV cycles after reset release.
- `led` is registered. It shows the new pattern on the edge after the state update, so there is 1 cycle of latency from step to `led`.
- In mode 2, `led` follows `pwm_cnt` with 1 cycle of latency.
- Mode change latency: after the `mode_load` edge, `led` shows the new mode's initial pattern one cycle later.
  - Count: 0.
  - Chase: bit 0.
  - Breathe: off.
  - All-on: all ones.
- If `mode_load` and the terminal `div_cnt` fall in the same cycle, the load wins. No step occurs, `tick` stays low and the prescaler restarts at 0.
- A `mode_load` held for several cycles restarts on every cycle. The first step then occurs TICK_DIV cycles after the last load cycle.
- Reset asserted mid-operation forces all outputs low immediately, without waiting for `clk`.

## Configuration
- `LED_PATTERN_BREATHE_EN` defined: mode 2 works as specified, and the `pwm_cnt`, `level` and `ramp` registers are built.
- Not defined:
  - Those registers are absent.
  - A load of `mode_in = 2` stores mode 0, and the block behaves exactly as count mode.
  - PWM_BITS is ignored.

## Test plan
Bench settings: `TICK_DIV=4`, `N_LEDS=5`, `PWM_BITS=3`, macro defined unless noted.
- Reset and count: release `rst_n`.
  - `tick` pulses at cycles 4, 8, 12, ...
  - `led` reads 0, 1, 2, ..., one cycle after each tick.
  - After 32 steps, `led` wraps from 31 to 0.
- Chase: load mode 1 and run 10 steps. `led` reads 00001, 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001, 00010.
- Breathe: load mode 2 and step until `level=3`. `led` is high for exactly 3 of each 8-cycle PWM period. Thereafter `level` follows 4, 5, 6, 7, 6, ..., 0.
- Collision: assert `mode_load` (mode 3) on the cycle where `div_cnt=3`.
  - No `tick` in that cycle.
  - `led` is 11111 on the next cycle.
  - The next `tick` comes 4 cycles later.
- Async reset: drop `rst_n` mid-chase, between clk edges. `led` and `tick` go to 0 before the next edge, and `mode` is 0 after release.
- Macro off: load mode 2. `led` counts 0, 1, 2 exactly as mode 0 does.
